// File: rtl/enc_pkg.sv
// Shared constants, FSM state type and the 4:2 priority helper for the 64-line drain encoder.
package enc_pkg;

  localparam int N     = 64;
  localparam int IDX_W = 6;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Index of the lowest set bit of a 4-bit group; 0 when the group is empty.
  function automatic logic [1:0] prio4(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    if (v[0])      r = 2'd0;
    else if (v[1]) r = 2'd1;
    else if (v[2]) r = 2'd2;
    else if (v[3]) r = 2'd3;
    return r;
  endfunction

endpackage

// File: rtl/prio_enc64.sv
// Combinational lowest-set-bit encoder: three levels of 4:2 priority stages,
// mirroring the three 2-bit index groups of the 6:64 decoder.
module prio_enc64
  import enc_pkg::*;
(
  input  logic [63:0] vec,
  output logic [5:0]  idx,
  output logic        found
);

  logic [15:0]      any1;
  logic [15:0][1:0] sub1;
  logic [3:0]       any2;
  logic [3:0][3:0]  sub2;
  logic [1:0]       sel3;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_lvl1
      assign any1[gi] = |vec[4*gi +: 4];
      assign sub1[gi] = prio4(vec[4*gi +: 4]);
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lvl2
      logic [3:0][1:0] grp;
      logic [1:0]      sel;
      assign grp          = sub1[4*gi +: 4];
      assign sel          = prio4(any1[4*gi +: 4]);
      assign any2[gi]     = |any1[4*gi +: 4];
      assign sub2[gi]     = {sel, grp[sel]};
    end
  endgenerate

  assign sel3  = prio4(any2);
  assign idx   = {sel3, sub2[sel3]};
  assign found = |any2;

endmodule

// File: rtl/encoder64_drain.sv
// Drains a 64-bit request vector as a stream of set-bit indices, lowest first,
// one beat per set bit with valid/ready handshaking on both sides.
module encoder64_drain #(
  parameter int N     = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] idx,
  output logic             last,
  output logic             busy
);
  import enc_pkg::*;

  state_t           state;
  logic [N-1:0]     pending;
  logic [N-1:0]     enc_in;
  logic [N-1:0]     enc_rest;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_found;

  // One shared encoder: sees the fresh request in IDLE, the leftovers in EMIT.
  assign enc_in   = (state == IDLE) ? req : pending;
  assign enc_rest = enc_in & (enc_in - N'(1));

  prio_enc64 u_prio (
    .vec   (enc_in),
    .idx   (enc_idx),
    .found (enc_found)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state == EMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      idx       <= '0;
      last      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && enc_found) begin
            idx       <= enc_idx;
            pending   <= enc_rest;
            last      <= (enc_rest == '0);
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (last) begin
              out_valid <= 1'b0;
              last      <= 1'b0;
              state     <= IDLE;
            end else begin
              idx     <= enc_idx;
              pending <= enc_rest;
              last    <= (enc_rest == '0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder64_drain.sv
// Directed bench for encoder64_drain: hand-picked vectors, beats checked against
// the expected ascending set-bit sequence on the falling clock edge.
module tb_encoder64_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] req;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  idx;
  logic        last;
  logic        busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  encoder64_drain #(.N(64), .IDX_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .req       (req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .idx       (idx),
    .last      (last),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Present vec for one accepting edge; returns at the falling edge after it.
  task automatic send(input logic [63:0] vec);
    chk("pre_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    req      = vec;
    @(negedge clk);
    in_valid = 1'b0;
    req      = '0;
  endtask

  // Expect one beat per set bit of vec, ascending; first beat stalled for 'stall' cycles.
  task automatic drain(input logic [63:0] vec, input int stall);
    logic [63:0] rem;
    bit          first;
    rem   = vec;
    first = 1'b1;
    for (int b = 0; b < 64; b++) begin
      if (rem[b]) begin
        rem[b] = 1'b0;
        if (first && stall > 0) begin
          out_ready = 1'b0;
          for (int s = 0; s < stall; s++) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_idx", 64'(idx), 64'(b));
            chk("stall_last", 64'(last), 64'(rem == 64'd0));
            @(negedge clk);
          end
        end
        first     = 1'b0;
        out_ready = 1'b1;
        chk("beat_valid", 64'(out_valid), 64'd1);
        chk("beat_idx", 64'(idx), 64'(b));
        chk("beat_last", 64'(last), 64'(rem == 64'd0));
        chk("beat_in_ready", 64'(in_ready), 64'd0);
        chk("beat_busy", 64'(busy), 64'd1);
        $display("beat idx=%0d last=%0b", idx, last);
        @(negedge clk);
      end
    end
    chk("done_valid", 64'(out_valid), 64'd0);
    chk("done_in_ready", 64'(in_ready), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    req       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_idx", 64'(idx), 64'd0);
    chk("rst_last", 64'(last), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Single low bit.
    $display("vector 0000000000000001");
    out_ready = 1'b1;
    send(64'h1);
    drain(64'h1, 0);

    // Both ends of the vector.
    $display("vector 8000000000000001");
    send(64'h8000_0000_0000_0001);
    drain(64'h8000_0000_0000_0001, 0);

    // All ones: 64 back-to-back beats.
    $display("vector ffffffffffffffff");
    send(64'hFFFF_FFFF_FFFF_FFFF);
    drain(64'hFFFF_FFFF_FFFF_FFFF, 0);

    // Backpressure on the first beat.
    $display("vector 0000000000010010 stall 3");
    send(64'h0000_0000_0001_0010);
    drain(64'h0000_0000_0001_0010, 3);

    // Scattered pattern crossing all group boundaries.
    $display("vector 0420008000100402");
    send(64'h0420_0080_0010_0402);
    drain(64'h0420_0080_0010_0402, 1);

    // Empty vector is consumed without any beat.
    $display("vector 0000000000000000");
    send(64'h0);
    for (int c = 0; c < 3; c++) begin
      chk("zero_valid", 64'(out_valid), 64'd0);
      chk("zero_in_ready", 64'(in_ready), 64'd1);
      chk("zero_busy", 64'(busy), 64'd0);
      @(negedge clk);
    end

    // Reset in the middle of a drain discards the rest.
    $display("vector 00000000000000ff reset after beat 1");
    out_ready = 1'b1;
    send(64'hFF);
    chk("r_beat0_idx", 64'(idx), 64'd0);
    chk("r_beat0_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    chk("r_beat1_idx", 64'(idx), 64'd1);
    chk("r_beat1_last", 64'(last), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("r_after_valid", 64'(out_valid), 64'd0);
    chk("r_after_in_ready", 64'(in_ready), 64'd1);
    chk("r_after_busy", 64'(busy), 64'd0);
    chk("r_after_last", 64'(last), 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("r_quiet_valid", 64'(out_valid), 64'd0);
    end

    // Block still works after the mid-drain reset.
    $display("vector 4000000000000000");
    send(64'h4000_0000_0000_0000);
    drain(64'h4000_0000_0000_0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
